ecdsa_host_seq: RTL and testbench
=================================

Name: ecdsa_host_seq

Overview:
- Stream-side initiator for the ECDSA core. Drives the curve configuration register write port and the point-generation engine's control/operand port.
- Accepts a serial word stream carrying curve parameters and the operands x, y and S.
- Issues one register write per parameter, runs one scalar multiplication, and streams the resulting point back out as words.

Parameters:
- WORD_W, 32, stream word width; must divide 256; WORDS = 256/WORD_W (8 at default).
- NUM_CFG, 6, number of 256-bit config values per frame; written to config addresses 0..NUM_CFG-1; max 16.
- TIMEOUT_CYCLES, 1000000, watchdog limit in GP_WAIT (ECDSA_TIMEOUT_EN only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  WORD_W  input stream word
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid&&s_ready
- m_data  out  WORD_W  result stream word
- m_valid  out  1  result word valid
- m_ready  in  1  downstream accepts result word
- m_last  out  1  final (16th) result word
- cfg_wr_en  out  1  config register write strobe
- cfg_addr  out  4  config register address
- cfg_data  out  256  config register write data
- gp_reset  out  1  point engine reset, active-high
- gp_point_x  out  256  base point x operand
- gp_point_y  out  256  base point y operand
- gp_scalar  out  256  scalar operand S
- gp_out_x  in  256  result x
- gp_out_y  in  256  result y
- gp_done  in  1  engine done (level)
- busy  out  1  high in every state except LOAD with val_idx=0 and word_cnt=0
- error  out  1  timeout flag (0 constant without macro)

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous active-low.
- Reset values: state=LOAD, val_idx=0, word_cnt=0, s_ready=0 for first cycle then 1, m_valid=0, m_last=0, m_data=0, cfg_wr_en=0, cfg_addr=0, cfg_data=0, gp_point_x/y/gp_scalar=0, gp_reset=1, busy=0, error=0.
- Assembly: 256-bit values arrive least-significant word first. Accepted word k lands at bits [k*WORD_W +: WORD_W]. word_cnt runs 0..WORDS-1 and wraps on the last word.
- LOAD: s_ready=1. On acceptance of the last word of a value:
  - if val_idx<NUM_CFG, go to CFG_WR;
  - else latch into gp_point_x (val_idx=NUM_CFG), gp_point_y (NUM_CFG+1), gp_scalar (NUM_CFG+2).
  - After gp_scalar, go to GP_RST. Otherwise val_idx++ and stay in LOAD.
- CFG_WR: exactly 1 cycle with s_ready=0 and cfg_wr_en=1, cfg_addr=val_idx, cfg_data=assembled value. Then val_idx++ and return to LOAD.
- Operand stability: gp_* operands hold stable from latch until the next frame's corresponding latch.
- GP_RST: gp_reset=1 for exactly 2 cycles, then GP_WAIT.
- gp_reset level: gp_reset=1 in every state except GP_WAIT (engine held in reset when idle).
- GP_WAIT: gp_reset=0. gp_done is ignored in the first GP_WAIT cycle. From the second cycle, gp_done=1 captures gp_out_x/gp_out_y into an output buffer and moves to SEND.
- SEND:
  - m_valid=1 for 16 beats: x words 0..WORDS-1, then y words, LSW first.
  - Advance only on m_valid&&m_ready. m_data and m_last stay stable while stalled.
  - m_last=1 on the final beat only.
  - After the final beat: val_idx=0, word_cnt=0, return to LOAD.
- Input gaps: s_valid gaps are allowed anywhere with no effect on results. s_ready=0 outside LOAD, so no words are dropped.
- Reset mid-operation: all state returns to reset values immediately. A partial frame is discarded and the next frame restarts at config address 0.
- Total latency: NUM_CFG+3 values in; operation start is 2 cycles after the S last word; first m_valid is 1 cycle after qualifying gp_done.

Optional Feature:
- Macro ECDSA_TIMEOUT_EN.
- Defined:
  - a counter clears on GP_WAIT entry and increments each GP_WAIT cycle;
  - reaching TIMEOUT_CYCLES without qualifying gp_done sets error=1 (sticky until rst_n) and moves to ERR;
  - ERR holds gp_reset=1, s_ready=0, m_valid=0 until reset.
- Undefined: no counter and no ERR state; GP_WAIT waits indefinitely; error tied to 0.

Test Plan:
- Frame with config value i = {8{32'h1000_0000+i}}, i=0..5 -> exactly 6 single-cycle cfg_wr_en pulses, cfg_addr 0..5, cfg_data matching; s_ready low exactly in those 6 cycles.
- Operands x=1, y=2, S=3; engine model asserts gp_done 10 cycles after gp_reset falls with gp_out_x=256'hABCD, gp_out_y=256'h1234 -> gp_point_x/y/gp_scalar=1/2/3; gp_reset high 2 cycles after S; m_data sequence 0xABCD,0×7,0x1234,0×7; m_last on beat 16 only.
- m_ready toggling every other cycle -> m_data/m_last stable across stalls; exactly 16 transfers; then back to LOAD with busy=0.
- s_valid with random 0-5 idle cycles between words -> cfg writes and operands identical to gapless run.
- gp_done forced high during GP_RST and the first GP_WAIT cycle, then low, then high at cycle 5 with different data -> only the cycle-5 data is transmitted.
- rst_n pulsed low in GP_WAIT -> all outputs at reset values asynchronously; new frame restarts at cfg_addr 0. With ECDSA_TIMEOUT_EN and TIMEOUT_CYCLES=50 and no gp_done -> error=1 after 50 GP_WAIT cycles, gp_reset=1, s_ready=0.

Source files
------------

// File: rtl/ecdsa_host_seq_if.sv
// Bundle of the ECDSA host sequencer's stream, config-write and point-engine signals.
// The master view belongs to the sequencer; the slave view belongs to whatever surrounds it.
interface ecdsa_host_seq_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    logic              cfg_wr_en;
    logic [3:0]        cfg_addr;
    logic [255:0]      cfg_data;

    logic              gp_reset;
    logic [255:0]      gp_point_x;
    logic [255:0]      gp_point_y;
    logic [255:0]      gp_scalar;
    logic [255:0]      gp_out_x;
    logic [255:0]      gp_out_y;
    logic              gp_done;

    logic              busy;
    logic              error;

    modport master (
        input  s_data, s_valid, m_ready, gp_out_x, gp_out_y, gp_done,
        output s_ready, m_data, m_valid, m_last, cfg_wr_en, cfg_addr, cfg_data,
               gp_reset, gp_point_x, gp_point_y, gp_scalar, busy, error
    );

    modport slave (
        output s_data, s_valid, m_ready, gp_out_x, gp_out_y, gp_done,
        input  s_ready, m_data, m_valid, m_last, cfg_wr_en, cfg_addr, cfg_data,
               gp_reset, gp_point_x, gp_point_y, gp_scalar, busy, error
    );
endinterface

// File: rtl/ecdsa_host_seq.sv
// ecdsa_host_seq: loads curve config and x/y/S from a word stream, runs one scalar multiply
// and streams the result point back out. Define ECDSA_TIMEOUT_EN to add the GP_WAIT watchdog.
module ecdsa_host_seq #(
    parameter int WORD_W         = 32,
    parameter int NUM_CFG        = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    ecdsa_host_seq_if.master bus
);
    localparam int WORDS = 256 / WORD_W;
    localparam int BEATS = 2 * WORDS;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW    = $clog2(BEATS);

    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS - 1);
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BEATS - 1);
    localparam logic [4:0]     IDX_X     = 5'(NUM_CFG);
    localparam logic [4:0]     IDX_Y     = 5'(NUM_CFG + 1);
    localparam logic [4:0]     IDX_S     = 5'(NUM_CFG + 2);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CFG_WR,
        S_GP_RST,
        S_GP_WAIT,
        S_SEND
`ifdef ECDSA_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      val_idx_q, val_idx_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic            rdy_en_q;
    logic [255:0]    asm_q, asm_d;
    logic [3:0]      cfg_addr_q, cfg_addr_d;
    logic [255:0]    cfg_data_q, cfg_data_d;
    logic [255:0]    gp_x_q, gp_x_d;
    logic [255:0]    gp_y_q, gp_y_d;
    logic [255:0]    gp_s_q, gp_s_d;
    logic            rst_cnt_q, rst_cnt_d;
    logic            wait_first_q, wait_first_d;
    logic [511:0]    res_q, res_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            s_ready_w;
    logic            accept;

`ifdef ECDSA_TIMEOUT_EN
    localparam int          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            error_q, error_d;
`endif

    // s_ready stays low for the first cycle out of reset
    assign s_ready_w = (state_q == S_LOAD) && rdy_en_q;
    assign accept    = s_ready_w && bus.s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            val_idx_q    <= '0;
            word_cnt_q   <= '0;
            rdy_en_q     <= 1'b0;
            asm_q        <= '0;
            cfg_addr_q   <= '0;
            cfg_data_q   <= '0;
            gp_x_q       <= '0;
            gp_y_q       <= '0;
            gp_s_q       <= '0;
            rst_cnt_q    <= 1'b0;
            wait_first_q <= 1'b0;
            res_q        <= '0;
            beat_q       <= '0;
`ifdef ECDSA_TIMEOUT_EN
            to_cnt_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            val_idx_q    <= val_idx_d;
            word_cnt_q   <= word_cnt_d;
            rdy_en_q     <= 1'b1;
            asm_q        <= asm_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_data_q   <= cfg_data_d;
            gp_x_q       <= gp_x_d;
            gp_y_q       <= gp_y_d;
            gp_s_q       <= gp_s_d;
            rst_cnt_q    <= rst_cnt_d;
            wait_first_q <= wait_first_d;
            res_q        <= res_d;
            beat_q       <= beat_d;
`ifdef ECDSA_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        val_idx_d    = val_idx_q;
        word_cnt_d   = word_cnt_q;
        asm_d        = asm_q;
        cfg_addr_d   = cfg_addr_q;
        cfg_data_d   = cfg_data_q;
        gp_x_d       = gp_x_q;
        gp_y_d       = gp_y_q;
        gp_s_d       = gp_s_q;
        rst_cnt_d    = rst_cnt_q;
        wait_first_d = wait_first_q;
        res_d        = res_q;
        beat_d       = beat_q;
`ifdef ECDSA_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        error_d      = error_q;
`endif

        // asm_d already holds the completed value on the last word of a value
        if (accept) begin
            asm_d[word_cnt_q*WORD_W +: WORD_W] = bus.s_data;
        end

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (word_cnt_q == WORD_LAST) begin
                        word_cnt_d = '0;
                        if (val_idx_q < IDX_X) begin
                            cfg_addr_d = val_idx_q[3:0];
                            cfg_data_d = asm_d;
                            state_d    = S_CFG_WR;
                        end else begin
                            if (val_idx_q == IDX_X) gp_x_d = asm_d;
                            if (val_idx_q == IDX_Y) gp_y_d = asm_d;
                            if (val_idx_q == IDX_S) begin
                                gp_s_d    = asm_d;
                                rst_cnt_d = 1'b0;
                                state_d   = S_GP_RST;
                            end else begin
                                val_idx_d = val_idx_q + 5'd1;
                            end
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_CFG_WR: begin
                val_idx_d = val_idx_q + 5'd1;
                state_d   = S_LOAD;
            end
            S_GP_RST: begin
                if (rst_cnt_q) begin
                    wait_first_d = 1'b1;
                    state_d      = S_GP_WAIT;
`ifdef ECDSA_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            S_GP_WAIT: begin
                // gp_done may still be stale from before the reset in the first cycle
                wait_first_d = 1'b0;
                if (!wait_first_q && bus.gp_done) begin
                    res_d   = {bus.gp_out_y, bus.gp_out_x};
                    beat_d  = '0;
                    state_d = S_SEND;
                end
`ifdef ECDSA_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_SEND: begin
                if (bus.m_ready) begin
                    if (beat_q == BEAT_LAST) begin
                        val_idx_d  = '0;
                        word_cnt_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
`ifdef ECDSA_TIMEOUT_EN
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            default: state_d = S_LOAD;
        endcase
    end

    assign bus.s_ready    = s_ready_w;
    assign bus.m_valid    = (state_q == S_SEND);
    assign bus.m_data     = (state_q == S_SEND) ? res_q[beat_q*WORD_W +: WORD_W] : '0;
    assign bus.m_last     = (state_q == S_SEND) && (beat_q == BEAT_LAST);
    assign bus.cfg_wr_en  = (state_q == S_CFG_WR);
    assign bus.cfg_addr   = cfg_addr_q;
    assign bus.cfg_data   = cfg_data_q;
    assign bus.gp_reset   = (state_q != S_GP_WAIT);
    assign bus.gp_point_x = gp_x_q;
    assign bus.gp_point_y = gp_y_q;
    assign bus.gp_scalar  = gp_s_q;
    assign bus.busy       = !((state_q == S_LOAD) && (val_idx_q == '0) && (word_cnt_q == '0));

`ifdef ECDSA_TIMEOUT_EN
    assign bus.error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_ecdsa_host_seq.sv
// Scoreboard bench for ecdsa_host_seq: config writes and result beats are queued when a frame
// is driven and checked as the sequencer emits them; a simple engine model answers gp_reset.
module tb_ecdsa_host_seq;
    localparam logic [255:0] RES_X  = 256'hABCD;
    localparam logic [255:0] RES_Y  = 256'h1234;
    localparam logic [255:0] BAD_V  = 256'hDEAD_BEEF;
    localparam logic [255:0] GOOD_X = {8{32'hCAFE_0001}};
    localparam logic [255:0] GOOD_Y = {8{32'h5A5A_0002}};

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [3:0]   addr;
        logic [255:0] data;
    } cfg_t;

    logic clk;
    logic rst_n;

    ecdsa_host_seq_if #(.WORD_W(32)) bus ();

    ecdsa_host_seq #(
        .WORD_W        (32),
        .NUM_CFG       (6),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    cfg_t  cfg_exp[$];
    int    cfg_cnt = 0;
    int    xfer_cnt = 0;
    int    s_low_cnt = 0;
    int    eng_mode = 0;
    bit    toggle_rdy = 0;
    bit    last_done = 0;
    int    frame_no = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    // engine model: mode 0 normal, 1 spurious early done, 2 never done
    initial begin
        int cyc;
        cyc = 0;
        bus.gp_done  = 1'b0;
        bus.gp_out_x = '0;
        bus.gp_out_y = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.gp_reset) cyc = 0;
            else              cyc++;
            case (eng_mode)
                0: begin
                    bus.gp_done  = (cyc >= 10);
                    bus.gp_out_x = RES_X;
                    bus.gp_out_y = RES_Y;
                end
                1: begin
                    if (bus.gp_reset || cyc == 1) begin
                        bus.gp_done  = 1'b1;
                        bus.gp_out_x = BAD_V;
                        bus.gp_out_y = BAD_V;
                    end else if (cyc >= 5) begin
                        bus.gp_done  = 1'b1;
                        bus.gp_out_x = GOOD_X;
                        bus.gp_out_y = GOOD_Y;
                    end else begin
                        bus.gp_done  = 1'b0;
                        bus.gp_out_x = BAD_V;
                        bus.gp_out_y = BAD_V;
                    end
                end
                default: bus.gp_done = 1'b0;
            endcase
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = toggle_rdy ? ~bus.m_ready : 1'b1;
        end
    end

    // result stream monitor, including stall stability
    initial begin
        logic [31:0] held_d;
        logic        held_l;
        bit          pend;
        int          n;
        beat_t       e;
        pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend) begin
                    check("stall_m_data", bus.m_data, held_d);
                    check("stall_m_last", bus.m_last, held_l);
                    pend = 0;
                end
                if (bus.m_valid) begin
                    if (!bus.m_ready) begin
                        held_d = bus.m_data;
                        held_l = bus.m_last;
                        pend   = 1;
                    end else begin
                        n = exp_q.size();
                        check("beat_expected", n != 0, 1);
                        if (n != 0) begin
                            e = exp_q.pop_front();
                            check("m_data", bus.m_data, e.data);
                            check("m_last", bus.m_last, e.last);
                        end
                        xfer_cnt++;
                        if (bus.m_last) last_done = 1;
                    end
                end
            end
        end
    end

    initial begin
        int   n;
        cfg_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.cfg_wr_en) begin
                n = cfg_exp.size();
                check("cfg_expected", n != 0, 1);
                if (n != 0) begin
                    e = cfg_exp.pop_front();
                    check("cfg_addr", bus.cfg_addr, e.addr);
                    check("cfg_data", bus.cfg_data, e.data);
                end
                cfg_cnt++;
            end
        end
    end

    function automatic void push_result(input logic [255:0] rx, input logic [255:0] ry);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.data = (k < 8) ? rx[k*32 +: 32] : ry[(k-8)*32 +: 32];
            b.last = (k == 15);
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        bus.s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            s_low_cnt++;
            n++;
            if (n >= 200) begin
                check("s_ready_wait", bus.s_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input logic [255:0] x, input logic [255:0] y,
                              input logic [255:0] s);
        logic [255:0] val;
        logic [31:0]  cw;
        cfg_t         c;
        s_low_cnt = 0;
        for (int v = 0; v < 9; v++) begin
            cw = 32'h1000_0000 + 32'(v);
            if (v < 6)       val = {8{cw}};
            else if (v == 6) val = x;
            else if (v == 7) val = y;
            else             val = s;
            if (v < 6) begin
                c.addr = 4'(v);
                c.data = val;
                cfg_exp.push_back(c);
            end
            for (int k = 0; k < 8; k++) begin
                send_word(val[k*32 +: 32], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
            end
        end
    endtask

    task automatic run_frame(input int gap, input int mode, input logic [255:0] x,
                             input logic [255:0] y, input logic [255:0] s,
                             input logic [255:0] rx, input logic [255:0] ry, input bit chk_low);
        int base_cfg, base_x, n;
        frame_no++;
        eng_mode  = mode;
        base_cfg  = cfg_cnt;
        base_x    = xfer_cnt;
        last_done = 0;
        if (mode != 2) push_result(rx, ry);
        send_frame(gap, x, y, s);
        if (chk_low) check("s_ready_low_cycles", s_low_cnt, 6);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.gp_reset) break;
            n++;
        end
        check("gp_reset_cycles", n, 2);
        check("gp_point_x", bus.gp_point_x, x);
        check("gp_point_y", bus.gp_point_y, y);
        check("gp_scalar", bus.gp_scalar, s);
        check("cfg_write_count", cfg_cnt - base_cfg, 6);
        if (mode != 2) begin
            n = 0;
            while (!last_done && n < 2000) begin
                @(posedge clk);
                n++;
            end
            check("last_beat_seen", last_done, 1);
            @(negedge clk);
            check("busy_after_send", bus.busy, 0);
            check("transfer_count", xfer_cnt - base_x, 16);
            @(posedge clk);
            #1;
        end
        $display("frame %0d: mode %0d, %0d cfg writes, %0d result beats", frame_no, mode,
                 cfg_cnt - base_cfg, xfer_cnt - base_x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_gp_reset"}, bus.gp_reset, 1);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_last"}, bus.m_last, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
        check({tag, "_cfg_wr_en"}, bus.cfg_wr_en, 0);
        check({tag, "_cfg_addr"}, bus.cfg_addr, 0);
        check({tag, "_cfg_data"}, bus.cfg_data, 0);
        check({tag, "_gp_point_x"}, bus.gp_point_x, 0);
        check({tag, "_gp_scalar"}, bus.gp_scalar, 0);
        check({tag, "_error"}, bus.error, 0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("por");
        #9 rst_n = 1'b1;
        #1 check("s_ready_first_cycle", bus.s_ready, 0);
        @(negedge clk);
        check("s_ready_after_first", bus.s_ready, 1);
        @(posedge clk);
        #1;

        // gapless frame, x=1 y=2 S=3
        run_frame(0, 0, 256'd1, 256'd2, 256'd3, RES_X, RES_Y, 1);
        // downstream stalls every other cycle
        toggle_rdy = 1;
        run_frame(0, 0, 256'd1, 256'd2, 256'd3, RES_X, RES_Y, 1);
        toggle_rdy = 0;
        // random input gaps, same frame content
        run_frame(5, 0, 256'd1, 256'd2, 256'd3, RES_X, RES_Y, 0);
        // early spurious gp_done must be ignored
        run_frame(0, 1, {4{64'h0123_4567_89AB_CDEF}}, 256'h77, 256'h99, GOOD_X, GOOD_Y, 1);

        // reset pulsed while waiting on the engine
        run_frame(0, 2, 256'd1, 256'd2, 256'd3, '0, '0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("cfg_queue_drained", cfg_exp.size(), 0);
        run_frame(0, 0, 256'h4, 256'h5, 256'h6, RES_X, RES_Y, 0);

`ifdef ECDSA_TIMEOUT_EN
        run_frame(0, 2, 256'd1, 256'd2, 256'd3, '0, '0, 1);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            if (bus.error) break;
            @(negedge clk);
            if (!bus.gp_reset) n++;
        end
        check("timeout_wait_cycles", n, 50);
        check("timeout_error", bus.error, 1);
        check("timeout_gp_reset", bus.gp_reset, 1);
        check("timeout_s_ready", bus.s_ready, 0);
        check("timeout_m_valid", bus.m_valid, 0);
`else
        n = 0;
        check("error_tied_low", bus.error, 0);
`endif
        check("result_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
